// File: rtl/memory_byte_adapter_pkg.sv
// Shared size/operation encodings for the arbiter, core and memory_byte_adapter.
package memory_byte_adapter_pkg;

   localparam logic [1:0] BYTE  = 2'd0;
   localparam logic [1:0] HALF  = 2'd1;
   localparam logic [1:0] WORD  = 2'd2;
   localparam logic       READ  = 1'b0;
   localparam logic       WRITE = 1'b1;

   // Index of the final byte of an access; the reserved size behaves as a word.
   function automatic logic [1:0] last_index(input logic [1:0] size);
      case (size)
         BYTE:    return 2'd0;
         HALF:    return 2'd1;
         default: return 2'd3;
      endcase
   endfunction

endpackage

// File: rtl/memory_byte_adapter.sv
// Splits sized 8/16/32-bit requests into byte accesses on an 8-bit synchronous RAM.
// Define MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN to reject misaligned halfword/word requests.
module memory_byte_adapter
   import memory_byte_adapter_pkg::*;
#(
   parameter int unsigned SIZE             = 32,
   parameter int unsigned RAM_ADDRESS_SIZE = 16
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic                        memory_enable,
   input  logic                        memory_operation,
   output logic                        memory_ready,
   input  logic [1:0]                  memory_data_size,
   input  logic [SIZE-1:0]             memory_address,
   output logic [SIZE-1:0]             memory_data_in,
   input  logic [SIZE-1:0]             memory_data_out,
   output logic                        memory_error,
   output logic [RAM_ADDRESS_SIZE-1:0] ram_address,
   output logic                        ram_write_enable,
   output logic [7:0]                  ram_write_data,
   input  logic [7:0]                  ram_read_data
);

   typedef enum logic [1:0] {StIdle, StAccess, StCapture, StDone} state_t;

   state_t          state_q;
   logic [1:0]      cnt_q;
   logic [1:0]      prev_cnt;
   logic [1:0]      last_q;
   logic            op_q;
   logic [SIZE-1:0] addr_q;
   logic [SIZE-1:0] wdata_q;
   logic [SIZE-1:0] rdata_q;
   logic            ready_q;
   logic            in_access;

`ifdef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
   logic error_q;
   logic misaligned;

   assign misaligned = (last_index(memory_data_size) == 2'd1 && memory_address[0]) ||
                       (last_index(memory_data_size) == 2'd3 && memory_address[1:0] != 2'b00);
   assign memory_error = error_q;
`else
   assign memory_error = 1'b0;
`endif

   // The byte returned in cycle i was addressed in cycle i-1.
   assign prev_cnt = cnt_q - 2'd1;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q <= StIdle;
         cnt_q   <= 2'd0;
         ready_q <= 1'b0;
         rdata_q <= '0;
`ifdef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
         error_q <= 1'b0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (memory_enable) begin
                  addr_q  <= memory_address;
                  last_q  <= last_index(memory_data_size);
                  op_q    <= memory_operation;
                  wdata_q <= memory_data_out;
                  rdata_q <= '0;
                  cnt_q   <= 2'd0;
`ifdef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
                  if (misaligned) begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                     error_q <= 1'b1;
                  end else begin
                     state_q <= StAccess;
                  end
`else
                  state_q <= StAccess;
`endif
               end
            end
            StAccess: begin
               if (op_q == READ && cnt_q != 2'd0) begin
                  rdata_q[{prev_cnt, 3'b000} +: 8] <= ram_read_data;
               end
               if (cnt_q == last_q) begin
                  cnt_q <= 2'd0;
                  if (op_q == READ) begin
                     state_q <= StCapture;
                  end else begin
                     state_q <= StDone;
                     ready_q <= 1'b1;
                  end
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            StCapture: begin
               rdata_q[{last_q, 3'b000} +: 8] <= ram_read_data;
               state_q <= StDone;
               ready_q <= 1'b1;
            end
            StDone: begin
               if (!memory_enable) begin
                  state_q <= StIdle;
                  ready_q <= 1'b0;
`ifdef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
                  error_q <= 1'b0;
`endif
               end
            end
         endcase
      end
   end

   assign in_access      = (state_q == StAccess);
   assign memory_ready   = ready_q;
   assign memory_data_in = rdata_q;

   // Reset gates the strobe so an interrupted write stops in the very cycle reset is applied.
   assign ram_write_enable = reset && in_access && (op_q == WRITE);
   assign ram_write_data   = ram_write_enable ? wdata_q[{cnt_q, 3'b000} +: 8] : 8'h00;
   assign ram_address      = in_access ? RAM_ADDRESS_SIZE'(addr_q + SIZE'(cnt_q)) : '0;

endmodule

// File: tb/tb_memory_byte_adapter.sv
// Scoreboard bench for memory_byte_adapter: directed requests against a byte-wide sync RAM model.
module tb_memory_byte_adapter;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        memory_enable = 1'b0;
   logic        memory_operation = 1'b0;
   logic        memory_ready;
   logic [1:0]  memory_data_size = 2'd0;
   logic [31:0] memory_address = 32'd0;
   logic [31:0] memory_data_in;
   logic [31:0] memory_data_out = 32'd0;
   logic        memory_error;
   logic [15:0] ram_address;
   logic        ram_write_enable;
   logic [7:0]  ram_write_data;
   logic [7:0]  ram_read_data = 8'h00;

   logic [7:0]  mem [0:65535] = '{default: 8'h00};
   int          cycle = 0;
   int          we_count = 0;
   int          checks = 0;
   int          failures = 0;

   typedef struct {
      logic [31:0] data;
      logic        err;
      int          lat;
      int          issue;
   } exp_t;

   exp_t exp_q[$];

   memory_byte_adapter dut (
      .clock            (clock),
      .reset            (reset),
      .memory_enable    (memory_enable),
      .memory_operation (memory_operation),
      .memory_ready     (memory_ready),
      .memory_data_size (memory_data_size),
      .memory_address   (memory_address),
      .memory_data_in   (memory_data_in),
      .memory_data_out  (memory_data_out),
      .memory_error     (memory_error),
      .ram_address      (ram_address),
      .ram_write_enable (ram_write_enable),
      .ram_write_data   (ram_write_data),
      .ram_read_data    (ram_read_data)
   );

   always #5 clock = ~clock;

   always @(posedge clock) begin
      cycle <= cycle + 1;
      if (ram_write_enable) begin
         mem[ram_address] <= ram_write_data;
         we_count <= we_count + 1;
      end
      ram_read_data <= mem[ram_address];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: each rising memory_ready retires the oldest expected response.
   initial begin
      logic prev_ready;
      exp_t e;
      prev_ready = 1'b0;
      forever begin
         @(negedge clock);
         if (memory_ready && !prev_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_ready", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("data_in", memory_data_in, e.data);
               check("error", {31'd0, memory_error}, {31'd0, e.err});
               check("latency", 32'(cycle - e.issue), 32'(e.lat));
            end
         end
         prev_ready = memory_ready;
      end
   end

   task automatic run_req(input logic op, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_data,
                          input logic exp_err, input int exp_lat, input int hold,
                          input int drop_after, output int ready_cycles);
      exp_t e;
      int t;
      @(negedge clock);
      memory_enable    = 1'b1;
      memory_operation = op;
      memory_data_size = size;
      memory_address   = addr;
      memory_data_out  = wdata;
      e.data  = exp_data;
      e.err   = exp_err;
      e.lat   = exp_lat;
      e.issue = cycle;
      exp_q.push_back(e);
      t = 0;
      while (!memory_ready && t < 20) begin
         @(negedge clock);
         t++;
         if (t == 1) begin
            // Request inputs must already be latched; disturb them.
            memory_operation = ~op;
            memory_data_size = ~size;
            memory_address   = ~addr;
            memory_data_out  = ~wdata;
         end
         if (t == drop_after) memory_enable = 1'b0;
      end
      if (!memory_ready) check("ready_timeout", 32'd0, 32'd1);
      ready_cycles = 0;
      while (memory_ready && ready_cycles < 20) begin
         ready_cycles++;
         if (ready_cycles > hold) memory_enable = 1'b0;
         @(negedge clock);
      end
      memory_enable = 1'b0;
      @(negedge clock);
   endtask

   initial begin
      int rc;
      int we0;

      repeat (3) @(negedge clock);
      check("rst_ready", {31'd0, memory_ready}, 32'd0);
      check("rst_error", {31'd0, memory_error}, 32'd0);
      check("rst_data_in", memory_data_in, 32'd0);
      check("rst_ram_we", {31'd0, ram_write_enable}, 32'd0);
      reset = 1'b1;
      @(negedge clock);

      run_req(1'b1, 2'd2, 32'h100, 32'h11223344, 32'h0, 1'b0, 5, 0, 0, rc);
      check("ram_100", {24'd0, mem[16'h100]}, 32'h44);
      check("ram_101", {24'd0, mem[16'h101]}, 32'h33);
      check("ram_102", {24'd0, mem[16'h102]}, 32'h22);
      check("ram_103", {24'd0, mem[16'h103]}, 32'h11);

      run_req(1'b0, 2'd2, 32'h100, 32'h0, 32'h11223344, 1'b0, 6, 0, 0, rc);
      run_req(1'b0, 2'd0, 32'h103, 32'h0, 32'h00000011, 1'b0, 3, 0, 0, rc);
      run_req(1'b0, 2'd1, 32'h102, 32'h0, 32'h00001122, 1'b0, 4, 0, 0, rc);

      we0 = we_count;
`ifdef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
      run_req(1'b1, 2'd1, 32'h201, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 0, rc);
      check("misaligned_we_pulses", 32'(we_count - we0), 32'd0);
      check("misaligned_ram_201", {24'd0, mem[16'h201]}, 32'h00);
      run_req(1'b0, 2'd2, 32'h102, 32'h0, 32'h0, 1'b1, 1, 0, 0, rc);
`else
      run_req(1'b1, 2'd1, 32'h201, 32'h0000BEEF, 32'h0, 1'b0, 3, 0, 0, rc);
      check("half_we_pulses", 32'(we_count - we0), 32'd2);
      check("ram_201", {24'd0, mem[16'h201]}, 32'hEF);
      check("ram_202", {24'd0, mem[16'h202]}, 32'hBE);
`endif

      run_req(1'b0, 2'd0, 32'h100, 32'h0, 32'h00000044, 1'b0, 3, 3, 0, rc);
      check("hold_ready_cycles", 32'(rc), 32'd4);

      run_req(1'b1, 2'd2, 32'h300, 32'hDEADBEEF, 32'h0, 1'b0, 5, 0, 2, rc);
      check("drop_ready_cycles", 32'(rc), 32'd1);
      check("ram_300", {24'd0, mem[16'h300]}, 32'hEF);
      check("ram_301", {24'd0, mem[16'h301]}, 32'hBE);
      check("ram_302", {24'd0, mem[16'h302]}, 32'hAD);
      check("ram_303", {24'd0, mem[16'h303]}, 32'hDE);

      // Reset during the second ACCESS cycle of a word write.
      we0 = we_count;
      @(negedge clock);
      memory_enable    = 1'b1;
      memory_operation = 1'b1;
      memory_data_size = 2'd2;
      memory_address   = 32'h400;
      memory_data_out  = 32'h55667788;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      check("abort_ready", {31'd0, memory_ready}, 32'd0);
      check("abort_error", {31'd0, memory_error}, 32'd0);
      check("abort_data_in", memory_data_in, 32'd0);
      check("abort_ram_we", {31'd0, ram_write_enable}, 32'd0);
      reset = 1'b1;
      memory_enable = 1'b0;
      @(negedge clock);
      check("abort_we_pulses", 32'(we_count - we0), 32'd1);
      check("abort_ram_400", {24'd0, mem[16'h400]}, 32'h88);
      check("abort_ram_401", {24'd0, mem[16'h401]}, 32'h00);
      check("abort_ram_403", {24'd0, mem[16'h403]}, 32'h00);
      run_req(1'b0, 2'd0, 32'h400, 32'h0, 32'h00000088, 1'b0, 3, 0, 0, rc);

`ifndef MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN
      run_req(1'b1, 2'd2, 32'hFFFFFFFE, 32'hCAFEF00D, 32'h0, 1'b0, 5, 0, 0, rc);
      check("wrap_ram_ffff", {24'd0, mem[16'hFFFF]}, 32'hF0);
      check("wrap_ram_0000", {24'd0, mem[16'h0000]}, 32'hFE);
      run_req(1'b0, 2'd2, 32'hFFFFFFFE, 32'h0, 32'hCAFEF00D, 1'b0, 6, 0, 0, rc);
      run_req(1'b0, 2'd1, 32'hFFFFFFFF, 32'h0, 32'h0000FEF0, 1'b0, 4, 0, 0, rc);
`endif

      repeat (2) @(negedge clock);
      check("responses_outstanding", 32'(exp_q.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/memory_byte_adapter.md
Name: memory_byte_adapter

Overview:
- Sits directly downstream of the memory arbiter and serves as the single memory slave behind it.
- Accepts the arbiter's sized 8/16/32-bit requests and splits each into sequential single-byte accesses to an 8-bit-wide synchronous RAM (one-cycle read latency).
- Assembles read data little-endian and returns it using the codebase's four-phase enable/ready handshake.

Parameters:
- SIZE, 32, width of the memory address and data buses.
- RAM_ADDRESS_SIZE, 16, width of the RAM byte address; ram_address = low RAM_ADDRESS_SIZE bits of the computed byte address.

Ports:
- clock  input  1  single clock for the whole block.
- reset  input  1  synchronous, active-low; reset==0 at a clock edge resets the block.
- memory_enable  input  1  request from the arbiter; held high until ready is seen.
- memory_operation  input  1  0 = read, 1 = write.
- memory_ready  output  1  access complete; held high until memory_enable is sampled low.
- memory_data_size  input  2  0 = byte, 1 = halfword, 2 = word, 3 = reserved (treated as word).
- memory_address  input  SIZE  byte address of the first byte.
- memory_data_in  output  SIZE  read data, zero-extended; valid while memory_ready is high.
- memory_data_out  input  SIZE  write data; lane 0 holds the lowest-address byte.
- memory_error  output  1  misaligned-access flag; see Optional Feature.
- ram_address  output  RAM_ADDRESS_SIZE  RAM byte address.
- ram_write_enable  output  1  write strobe for the current byte.
- ram_write_data  output  8  byte to write.
- ram_read_data  input  8  byte addressed in the previous cycle.

Behaviour:
- States: IDLE, ACCESS, CAPTURE, DONE. Reset enters IDLE.
- Reset values: memory_ready=0, memory_error=0, memory_data_in=0, ram_write_enable=0, byte counter=0. Reset mid-access abandons the access immediately; no further RAM writes.
- IDLE:
  - enable==1 at an edge latches address, size, operation and data_out, clears the data register and goes to ACCESS.
  - The latched copy is used for the rest of the access; later input changes are ignored.
- Byte count N = 1, 2 or 4.
- ACCESS (N cycles, counter i = 0..N-1):
  - ram_address = latched address + i, modulo 2^SIZE, then truncated.
  - Write: ram_write_enable=1 and ram_write_data = byte lane i of the latched data.
  - Read: ram_write_enable=0; for i>0, ram_read_data is captured into lane i-1.
  - After the last byte: read goes to CAPTURE, write goes to DONE.
- CAPTURE (reads only, 1 cycle): captures ram_read_data into lane N-1, then goes to DONE.
- DONE:
  - memory_ready=1 and memory_data_in holds the assembled data; unused upper lanes are 0.
  - enable==0 at an edge goes to IDLE with ready=0 in the next cycle.
  - If enable is already low on entry, DONE lasts exactly one cycle.
- Latency, measured from the first edge sampling enable=1 to the first cycle with ready=1:
  - read: N+2 cycles (byte 3, halfword 4, word 6).
  - write: N+1 cycles (byte 2, halfword 3, word 5).
- Enable dropped mid-access: the access still completes and DONE lasts one cycle. There is no abort.
- ram_write_enable is never high outside ACCESS.
- Back-to-back requests: a new request is accepted only from IDLE, so there is at least one idle cycle between accesses.
- Address wrap at 2^SIZE-1 continues at 0.

Optional Feature:
- Macro MEMORY_BYTE_ADAPTER_ALIGN_CHECK_EN.
- Defined:
  - In IDLE, a request is misaligned when a halfword has address[0]!=0 or a word has address[1:0]!=0.
  - A misaligned request goes straight to DONE with memory_error=1 and memory_data_in=0, and issues no RAM access.
  - Latency is 1 cycle; memory_error clears with ready.
- Not defined: memory_error is tied to 0 and misaligned accesses are performed byte-wise as normal.

Decomposition:
- Shared package/header: size encoding constants (BYTE=0, HALF=1, WORD=2) and operation constants (READ=0, WRITE=1), shared with the arbiter and the core.
- The state encoding stays local.
- No sub-module; a behavioural 8-bit sync RAM model belongs in the bench only.

Test Plan:
- Word write 0x11223344 to 0x100, then word read of 0x100 -> RAM bytes 0x100..0x103 = 44,33,22,11; read returns 0x11223344; ready on the 5th and 6th cycles respectively.
- Byte read at 0x103 after the above -> data_in=0x00000011, ready 3 cycles after enable.
- Halfword write 0xBEEF to 0x201 with the macro undefined -> bytes 0x201=EF, 0x202=BE; error=0. Same with the macro defined -> ready after 1 cycle, error=1, no ram_write_enable pulse.
- Enable held 3 extra cycles after ready -> ready stays high for 4 cycles; the next request is accepted only after enable is sampled low.
- Enable dropped during ACCESS of a word write -> all 4 bytes still written; ready high for exactly 1 cycle.
- reset=0 asserted in the 2nd ACCESS cycle of a word write -> only byte 0 written; all outputs 0 next cycle; the next request works normally.
